// File: rtl/ndata_to_axi_typed_packer_pkg.sv
// Shared types and type helpers for the typed ndata-to-AXI packer.
package ndata_to_axi_typed_packer_pkg;

    typedef logic [63:0] data64_t;

    // Element type carried on the side type stream.
    typedef enum logic [2:0] {
        TypeU8   = 3'd0,
        TypeU16  = 3'd1,
        TypeU32  = 3'd2,
        TypeU64  = 3'd3,
        TypeF32  = 3'd4,
        TypeF64  = 3'd5,
        TypeI24  = 3'd6,
        TypeNone = 3'd7
    } type_t;

    // Slot counter width; covers the largest pack ratio of 8.
    localparam int unsigned SlotW = 3;

    function automatic int unsigned GET_TYPE_WIDTH(type_t t);
        case (t)
            TypeU8:           return 8;
            TypeU16:          return 16;
            TypeU32, TypeF32: return 32;
            TypeU64, TypeF64: return 64;
            TypeI24:          return 24;
            default:          return 0;
        endcase
    endfunction

    function automatic logic TYPE_WIDTH_SUPPORTED(type_t t);
        int unsigned w;
        w = GET_TYPE_WIDTH(t);
        return (w == 8) || (w == 16) || (w == 32) || (w == 64);
    endfunction

    // Input beats per output beat; unsupported widths pack as 64-bit.
    function automatic logic [3:0] TYPE_PACK_RATIO(type_t t);
        case (GET_TYPE_WIDTH(t))
            8:       return 4'd8;
            16:      return 4'd4;
            32:      return 4'd2;
            default: return 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/ndata_to_axi_typed_packer_ndata_slot_placer.sv
// Combinational placer: drops one ndata beat into slot s of a wide AXI beat
// for the element width implied by the pack ratio, plus the slot's masks.
module ndata_slot_placer
    import ndata_to_axi_typed_packer_pkg::*;
#(
    parameter int unsigned NUM_ELEMENTS = 8
) (
    input  logic [3:0]                     ratio_i,
    input  logic [SlotW-1:0]               slot_i,
    input  data64_t [NUM_ELEMENTS-1:0]     data_i,
    input  logic [NUM_ELEMENTS-1:0]        keep_i,
    output logic [64*NUM_ELEMENTS-1:0]     data_o,
    output logic [64*NUM_ELEMENTS-1:0]     data_mask_o,
    output logic [8*NUM_ELEMENTS-1:0]      keep_o,
    output logic [8*NUM_ELEMENTS-1:0]      keep_mask_o
);

    localparam int unsigned N = NUM_ELEMENTS;

    // Place elements; the slot index is narrowed per ratio so it never overruns.
    always_comb begin
        data_o      = '0;
        data_mask_o = '0;
        keep_o      = '0;
        keep_mask_o = '0;
        case (ratio_i)
            4'd8: begin
                data_mask_o[32'(slot_i) * N * 8 +: N * 8] = '1;
                keep_mask_o[32'(slot_i) * N +: N]         = '1;
                for (int unsigned i = 0; i < N; i++) begin
                    data_o[(32'(slot_i) * N + i) * 8 +: 8] = data_i[i][7:0];
                    keep_o[32'(slot_i) * N + i]            = keep_i[i];
                end
            end
            4'd4: begin
                data_mask_o[32'(slot_i[1:0]) * N * 16 +: N * 16] = '1;
                keep_mask_o[32'(slot_i[1:0]) * N * 2 +: N * 2]   = '1;
                for (int unsigned i = 0; i < N; i++) begin
                    data_o[(32'(slot_i[1:0]) * N + i) * 16 +: 16] = data_i[i][15:0];
                    keep_o[(32'(slot_i[1:0]) * N + i) * 2 +: 2]   = {2{keep_i[i]}};
                end
            end
            4'd2: begin
                data_mask_o[32'(slot_i[0]) * N * 32 +: N * 32] = '1;
                keep_mask_o[32'(slot_i[0]) * N * 4 +: N * 4]   = '1;
                for (int unsigned i = 0; i < N; i++) begin
                    data_o[(32'(slot_i[0]) * N + i) * 32 +: 32] = data_i[i][31:0];
                    keep_o[(32'(slot_i[0]) * N + i) * 4 +: 4]   = {4{keep_i[i]}};
                end
            end
            default: begin
                data_mask_o = '1;
                keep_mask_o = '1;
                for (int unsigned i = 0; i < N; i++) begin
                    data_o[i * 64 +: 64] = data_i[i];
                    keep_o[i * 8 +: 8]   = {8{keep_i[i]}};
                end
            end
        endcase
    end

endmodule

// File: rtl/ndata_to_axi_typed_packer.sv
// Packs a typed ndata stream into a 64*NUM_ELEMENTS-bit AXI4S stream with a
// registered output stage and an error pulse for unsupported element types.
module ndata_to_axi_typed_packer
    import ndata_to_axi_typed_packer_pkg::*;
#(
    parameter int unsigned NUM_ELEMENTS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         actual_type_valid_i,
    input  type_t                        actual_type_data_i,
    output logic                         actual_type_ready_o,
    input  logic                         in_valid_i,
    input  data64_t [NUM_ELEMENTS-1:0]   in_data_i,
    input  logic [NUM_ELEMENTS-1:0]      in_keep_i,
    input  logic                         in_last_i,
    output logic                         in_ready_o,
    output logic [64*NUM_ELEMENTS-1:0]   out_tdata_o,
    output logic [8*NUM_ELEMENTS-1:0]    out_tkeep_o,
    output logic                         out_tlast_o,
    output logic                         out_tvalid_o,
    input  logic                         out_tready_i,
    output logic                         type_err_o
);

    localparam int unsigned AXI_WIDTH = 64 * NUM_ELEMENTS;
    localparam int unsigned KEEP_WIDTH = AXI_WIDTH / 8;

    logic [SlotW-1:0]      s_q, s_d;
    logic [AXI_WIDTH-1:0]  acc_data_q;
    logic [KEEP_WIDTH-1:0] acc_keep_q;
    logic [AXI_WIDTH-1:0]  out_tdata_q;
    logic [KEEP_WIDTH-1:0] out_tkeep_q;
    logic                  out_tlast_q;
    logic                  out_tvalid_q, out_tvalid_d;
    logic                  type_err_q;

    logic [3:0]            ratio;
    logic                  supported;
    logic                  accept;
    logic                  last_slot;
    logic                  complete;
    logic [AXI_WIDTH-1:0]  place_data, data_mask, base_data, merged_data;
    logic [KEEP_WIDTH-1:0] place_keep, keep_mask, base_keep, merged_keep;

    assign ratio     = TYPE_PACK_RATIO(actual_type_data_i);
    assign supported = TYPE_WIDTH_SUPPORTED(actual_type_data_i);

    // Every input beat waits for a type and for room in the output register.
    assign in_ready_o          = actual_type_valid_i && (!out_tvalid_q || out_tready_i);
    assign accept              = in_valid_i && in_ready_o;
    assign actual_type_ready_o = in_valid_i && in_last_i && in_ready_o;
    assign last_slot           = ({1'b0, s_q} == (ratio - 4'd1));
    assign complete            = accept && (in_last_i || last_slot);

    ndata_slot_placer #(
        .NUM_ELEMENTS (NUM_ELEMENTS)
    ) u_placer (
        .ratio_i     (ratio),
        .slot_i      (s_q),
        .data_i      (in_data_i),
        .keep_i      (in_keep_i),
        .data_o      (place_data),
        .data_mask_o (data_mask),
        .keep_o      (place_keep),
        .keep_mask_o (keep_mask)
    );

    // Slot 0 starts from an empty accumulator so unfilled slots carry keep 0.
    assign base_data   = (s_q == '0) ? '0 : acc_data_q;
    assign base_keep   = (s_q == '0) ? '0 : acc_keep_q;
    assign merged_data = (base_data & ~data_mask) | place_data;
    assign merged_keep = (base_keep & ~keep_mask) | place_keep;

    // Next slot and output-valid: valid stays up across back-to-back completions.
    always_comb begin
        s_d = s_q;
        if (accept) begin
            s_d = complete ? '0 : s_q + 3'd1;
        end
        out_tvalid_d = out_tvalid_q;
        if (complete) begin
            out_tvalid_d = 1'b1;
        end else if (out_tready_i) begin
            out_tvalid_d = 1'b0;
        end
    end

    // Slot counter, accumulator and registered AXI output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q          <= '0;
            acc_data_q   <= '0;
            acc_keep_q   <= '0;
            out_tdata_q  <= '0;
            out_tkeep_q  <= '0;
            out_tlast_q  <= 1'b0;
            out_tvalid_q <= 1'b0;
            type_err_q   <= 1'b0;
        end else begin
            s_q          <= s_d;
            out_tvalid_q <= out_tvalid_d;
            type_err_q   <= accept && !supported;
            if (accept && !complete) begin
                acc_data_q <= merged_data;
                acc_keep_q <= merged_keep;
            end
            if (complete) begin
                out_tdata_q <= merged_data;
                out_tkeep_q <= merged_keep;
                out_tlast_q <= in_last_i;
            end
        end
    end

    assign out_tdata_o  = out_tdata_q;
    assign out_tkeep_o  = out_tkeep_q;
    assign out_tlast_o  = out_tlast_q;
    assign out_tvalid_o = out_tvalid_q;
    assign type_err_o   = type_err_q;

endmodule
